instr_fetch: RTL and testbench

- Instruction-fetch stage of the single-cycle MIPS CPU. Sits directly upstream of the decode field splitter.
- Owns the PC register and issues word reads to instruction memory over a req/ack handshake.
- Presents the fetched 32-bit instruction word and its PC to decode.
- Computes the next PC from PC+4, branch, jump (26-bit instrIndex) or register-jump (jr) redirects reported back by execute.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ack, and
// steers the next PC from branch/jump/jr redirects. Optional macro: FETCH_MISALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_fault,
`endif
  output logic [31:0] ins_data,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, FETCH, VALID, FAULT} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, VALID} state_t;
`endif

  state_t      state, state_nxt;
  logic        consume;
  logic        fault_jr;
  logic [31:0] branch_off;
  logic [31:0] jr_addr;
  logic [31:0] npc;

  assign consume    = (state == VALID) && !stall;
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
  assign jr_addr  = jr_target;
  assign fault_jr = consume && jr && (jr_target[1:0] != 2'b00);
`else
  // Without the fault path, a misaligned jr target is silently word-aligned.
  assign jr_addr  = jr_target & 32'hFFFF_FFFC;
  assign fault_jr = 1'b0;
`endif

  always_comb begin
    if (jr)
      npc = jr_addr;
    else if (jump)
      npc = {pc_plus4[31:28], instr_index, 2'b00};
    else if (branch_taken)
      npc = pc_plus4 + branch_off;
    else
      npc = pc_plus4;
  end

  // State register and the datapath registers it qualifies.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      ins_data  <= 32'd0;
      ins_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ins_valid <= (state_nxt == VALID);
      if (consume)
        pc <= npc;
      if (imem_req && imem_ack)
        ins_data <= imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (fault_jr)
        fetch_fault <= 1'b1;
`endif
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: if (imem_ack) state_nxt = VALID;
      VALID: begin
        if (consume) begin
          if (fault_jr)
`ifdef FETCH_MISALIGN_CHECK_EN
            state_nxt = FAULT;
`else
            state_nxt = VALID;
`endif
          else if (!imem_ack)
            state_nxt = FETCH;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // The redirected address goes out in the consume cycle itself for zero-wait fetch.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      FETCH: imem_req = 1'b1;
      VALID: begin
        if (consume && !fault_jr) begin
          imem_req  = 1'b1;
          imem_addr = npc;
        end
      end
      default: imem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences for boot, ack latency and
// stall, plus a table of redirect vectors applied from a known PC.
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jr;
  logic [15:0] branch_imm;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic        imem_req, imem_ack, ins_valid;
  logic [31:0] imem_addr, imem_rdata, ins_data, pc, pc_plus4;
  logic        ack_tie, ack_man;
  logic [31:0] held;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_tie ? imem_req : ack_man;
  assign imem_rdata = imem_addr ^ K;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .instr_index(instr_index),
    .jr(jr), .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_fault(fetch_fault),
`endif
    .ins_data(ins_data), .ins_valid(ins_valid), .pc(pc), .pc_plus4(pc_plus4)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] idx;
    logic        jrv;
    logic [31:0] jrt;
    logic        stl;
    logic        exp_req;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'd0; jump = 1'b0;
    instr_index = 26'd0; jr = 1'b0; jr_target = 32'd0;
  endtask

  // Redirect through a jr so the next presented instruction sits at target.
  task automatic set_pc(input logic [31:0] target);
    clear_inputs();
    jr = 1'b1;
    jr_target = target;
    tick();
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0040_0010, 1'b1, 16'hFFFC, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_0004};
    vecs[1] = '{32'h0040_0010, 1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_0020};
    vecs[2] = '{32'h0040_0000, 1'b1, 16'h0005, 1'b1, 26'h0100003, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_000C};
    vecs[3] = '{32'h0040_0000, 1'b1, 16'h0005, 1'b1, 26'h0100003, 1'b1, 32'h0040_1234, 1'b0, 1'b1, 32'h0040_1234};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 16'h0000, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'hBFC0_0010, 1'b0, 16'h0000, 1'b1, 26'h3FFFFFF, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBFFF_FFFC};
    vecs[6] = '{32'h0040_0010, 1'b1, 16'h0008, 1'b0, 26'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h0040_0010};
    vecs[7] = '{32'h0040_0000, 1'b1, 16'h7FFF, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0042_0000};
    vecs[8] = '{32'h0040_0000, 1'b1, 16'h8000, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h003E_0004};
    vecs[9] = '{32'h1234_5670, 1'b0, 16'h0000, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5674};

    clear_inputs();
    ack_tie = 1'b0;
    ack_man = 1'b1;  // ack while in reset must be ignored
    do_reset();
    ack_tie = 1'b1;
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_pc", pc, 32'hBFC0_0000);
    check("rst_data", ins_data, 32'd0);
    check("boot_req", {31'd0, imem_req}, 32'd0);

    // Zero-wait fetch after boot.
    tick();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr0", imem_addr, 32'hBFC0_0000);
    check("fetch_valid0", {31'd0, ins_valid}, 32'd0);
    tick();
    check("v1_valid", {31'd0, ins_valid}, 32'd1);
    check("v1_pc", pc, 32'hBFC0_0000);
    check("v1_data", ins_data, 32'hBFC0_0000 ^ K);
    check("v1_addr", imem_addr, 32'hBFC0_0004);
    tick();
    check("v2_pc", pc, 32'hBFC0_0004);
    check("v2_data", ins_data, 32'hBFC0_0004 ^ K);
    check("v2_addr", imem_addr, 32'hBFC0_0008);
    check("v2_plus4", pc_plus4, 32'hBFC0_0008);

    // Mid-stream reset with ack present, then a slow memory.
    ack_tie = 1'b0;
    ack_man = 1'b1;
    do_reset();
    check("rst2_valid", {31'd0, ins_valid}, 32'd0);
    check("rst2_pc", pc, 32'hBFC0_0000);
    tick();  // FETCH, ack_man=1
    tick();  // VALID at BFC00000
    ack_man = 1'b0;
    #1;
    check("lat_consume_addr", imem_addr, 32'hBFC0_0004);
    tick();
    check("lat_w1_req", {31'd0, imem_req}, 32'd1);
    check("lat_w1_addr", imem_addr, 32'hBFC0_0004);
    check("lat_w1_valid", {31'd0, ins_valid}, 32'd0);
    tick();
    check("lat_w2_req", {31'd0, imem_req}, 32'd1);
    check("lat_w2_addr", imem_addr, 32'hBFC0_0004);
    check("lat_w2_valid", {31'd0, ins_valid}, 32'd0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    check("lat_done_valid", {31'd0, ins_valid}, 32'd1);
    check("lat_done_pc", pc, 32'hBFC0_0004);
    check("lat_done_data", ins_data, 32'hBFC0_0004 ^ K);

    // Stall with a jump asserted and a stray ack: nothing may change.
    stall = 1'b1;
    jump = 1'b1;
    instr_index = 26'h0000100;
    ack_man = 1'b1;
    held = ins_data;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_req", i), {31'd0, imem_req}, 32'd0);
      tick();
      check($sformatf("stall%0d_pc", i), pc, 32'hBFC0_0004);
      check($sformatf("stall%0d_data", i), ins_data, held);
      check($sformatf("stall%0d_valid", i), {31'd0, ins_valid}, 32'd1);
    end
    ack_tie = 1'b1;
    clear_inputs();
    #1;
    check("unstall_addr", imem_addr, 32'hBFC0_0008);
    tick();
    check("unstall_pc", pc, 32'hBFC0_0008);

    // Redirect table, each vector applied from a known PC.
    for (int v = 0; v < 10; v++) begin
      set_pc(vecs[v].start_pc);
      check($sformatf("vec%0d_start", v), pc, vecs[v].start_pc);
      check($sformatf("vec%0d_plus4", v), pc_plus4, vecs[v].start_pc + 32'd4);
      branch_taken = vecs[v].br;
      branch_imm   = vecs[v].imm;
      jump         = vecs[v].jmp;
      instr_index  = vecs[v].idx;
      jr           = vecs[v].jrv;
      jr_target    = vecs[v].jrt;
      stall        = vecs[v].stl;
      #1;
      check($sformatf("vec%0d_req", v), {31'd0, imem_req}, {31'd0, vecs[v].exp_req});
      if (vecs[v].exp_req)
        check($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp_pc);
      tick();
      check($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      if (vecs[v].exp_req)
        check($sformatf("vec%0d_data", v), ins_data, vecs[v].exp_pc ^ K);
      clear_inputs();
    end

    // Misaligned jr target.
    set_pc(32'h0040_0010);
    jr = 1'b1;
    jr_target = 32'h0040_0002;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_req", {31'd0, imem_req}, 32'd0);
    tick();
    clear_inputs();
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_valid", {31'd0, ins_valid}, 32'd0);
    check("mis_pc", pc, 32'h0040_0002);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fault%0d_req", i), {31'd0, imem_req}, 32'd0);
      check($sformatf("fault%0d_flag", i), {31'd0, fetch_fault}, 32'd1);
    end
    do_reset();
    check("fault_clr", {31'd0, fetch_fault}, 32'd0);
    check("fault_rst_pc", pc, 32'hBFC0_0000);
`else
    check("mis_req", {31'd0, imem_req}, 32'd1);
    check("mis_addr", imem_addr, 32'h0040_0000);
    tick();
    clear_inputs();
    check("mis_pc", pc, 32'h0040_0000);
    check("mis_valid", {31'd0, ins_valid}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
